aipp_dispatch_lease_scheduler: RTL

- Shares the clock-gated cluster datapath among several GPU command-processor requesters.
- Each winning request receives a compute lease: the requested clusters are clock-enabled one at a time (staggered to bound di/dt), held for a burst count, then disabled one at a time.
- Sits between the command processors and the per-cluster clock-gate/bias cells.
- Enforces the network switch's temporal-token permission throughout the lease.

---
 rtl/aipp_sched_pkg.sv | 35 +++
 rtl/aipp_rr_arbiter.sv | 44 ++++
 rtl/aipp_dispatch_lease_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aipp_sched_pkg.sv
// rtl/aipp_sched_pkg.sv - shared types, defaults and bit-search helpers for the lease scheduler
package aipp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_NUM_CLUSTERS = 16;
  localparam int DEF_RAMP_GAP     = 8;
  localparam int DEF_LEN_W        = 16;
  localparam int MAX_CLUSTERS     = 64;

  function automatic int lowest_set_idx(input logic [MAX_CLUSTERS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CLUSTERS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int highest_set_idx(input logic [MAX_CLUSTERS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CLUSTERS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/aipp_rr_arbiter.sv
// rtl/aipp_rr_arbiter.sv - round-robin one-hot grant; search starts one past the last winner
module aipp_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    if (enable && found) grant[grant_idx] = 1'b1;
  end

  // A granted request always transfers, so the pointer advances on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/aipp_dispatch_lease_scheduler.sv
// rtl/aipp_dispatch_lease_scheduler.sv - grants compute leases and staggers cluster clock enables
module aipp_dispatch_lease_scheduler
  import aipp_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
  parameter int RAMP_GAP     = DEF_RAMP_GAP,
  parameter int LEN_W        = DEF_LEN_W
) (
  input  logic                            clk_omega,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*NUM_CLUSTERS-1:0] req_cluster_mask,
  input  logic [NUM_REQ*LEN_W-1:0]        req_burst_len,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            token_valid,
  input  logic                            token_revoke,
  output logic [NUM_CLUSTERS-1:0]         cluster_clock_en,
  output logic [NUM_CLUSTERS-1:0]         cluster_bias_ctrl,
  output logic                            dispatch_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            done_pulse,
  output logic                            abort_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (RAMP_GAP > 1) ? $clog2(RAMP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(RAMP_GAP - 1);

  sched_state_e            state, state_nxt;
  logic [NUM_CLUSTERS-1:0] pend, pend_nxt, en_nxt;
  logic [NUM_CLUSTERS-1:0] win_mask, low_bit, high_bit, pend_after, en_cleared;
  logic [LEN_W-1:0]        len_q, len_nxt, run_cnt, run_nxt, win_len;
  logic [GAP_W-1:0]        gap, gap_nxt;
  logic [IDX_W-1:0]        grant_idx, grant_id_nxt;
  logic                    dr_nxt, done_nxt, abort_nxt, abort_flag, abort_flag_nxt;
  logic                    arb_enable, accept, token_bad;

  // Pulse cycles are kept grant-free so the CP sees completion before re-arbitration.
  assign arb_enable = rst_n && (state == IDLE) && token_valid && !token_revoke
                      && !done_pulse && !abort_pulse;
  assign accept     = |req_ready;
  assign token_bad  = !token_valid || token_revoke;

  aipp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk_omega),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (arb_enable),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    win_mask = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win_mask = req_cluster_mask[i*NUM_CLUSTERS +: NUM_CLUSTERS];
        win_len  = req_burst_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign low_bit    = NUM_CLUSTERS'(1) << lowest_set_idx(MAX_CLUSTERS'(pend));
  assign high_bit   = NUM_CLUSTERS'(1) << highest_set_idx(MAX_CLUSTERS'(cluster_clock_en));
  assign pend_after = pend & ~low_bit;
  assign en_cleared = cluster_clock_en & ~high_bit;

  always_comb begin
    state_nxt      = state;
    pend_nxt       = pend;
    len_nxt        = len_q;
    run_nxt        = run_cnt;
    gap_nxt        = gap;
    en_nxt         = cluster_clock_en;
    dr_nxt         = dispatch_ready;
    grant_id_nxt   = grant_id;
    abort_flag_nxt = abort_flag;
    done_nxt       = 1'b0;
    abort_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pend_nxt       = win_mask;
          len_nxt        = win_len;
          grant_id_nxt   = grant_idx;
          gap_nxt        = '0;
          abort_flag_nxt = 1'b0;
          state_nxt      = RAMP;
        end
      end
      RAMP: begin
        if (token_bad) begin
          state_nxt      = DRAIN;
          gap_nxt        = '0;
          abort_flag_nxt = 1'b1;
          pend_nxt       = '0;
          dr_nxt         = 1'b0;
        end else if (pend == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (gap == '0) begin
          en_nxt   = cluster_clock_en | low_bit;
          pend_nxt = pend_after;
          gap_nxt  = GAP_RELOAD;
          if (pend_after == '0) begin
            state_nxt = RUN;
            dr_nxt    = 1'b1;
            run_nxt   = (len_q == '0) ? LEN_W'(1) : len_q;
          end
        end else begin
          gap_nxt = gap - GAP_W'(1);
        end
      end
      RUN: begin
        if (token_bad) begin
          state_nxt      = DRAIN;
          gap_nxt        = '0;
          abort_flag_nxt = 1'b1;
          pend_nxt       = '0;
          dr_nxt         = 1'b0;
        end else if (run_cnt == LEN_W'(1)) begin
          state_nxt = DRAIN;
          dr_nxt    = 1'b0;
          gap_nxt   = '0;
        end else begin
          run_nxt = run_cnt - LEN_W'(1);
        end
      end
      DRAIN: begin
        // An abort before any enable reaches here with nothing to clear and finishes at once.
        if (gap == '0) begin
          en_nxt  = en_cleared;
          gap_nxt = GAP_RELOAD;
          if (en_cleared == '0) begin
            state_nxt = IDLE;
            done_nxt  = !abort_flag;
            abort_nxt = abort_flag;
          end
        end else begin
          gap_nxt = gap - GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_omega or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pend              <= '0;
      len_q             <= '0;
      run_cnt           <= '0;
      gap               <= '0;
      cluster_clock_en  <= '0;
      cluster_bias_ctrl <= '1;
      dispatch_ready    <= 1'b0;
      grant_id          <= '0;
      done_pulse        <= 1'b0;
      abort_pulse       <= 1'b0;
      abort_flag        <= 1'b0;
    end else begin
      state             <= state_nxt;
      pend              <= pend_nxt;
      len_q             <= len_nxt;
      run_cnt           <= run_nxt;
      gap               <= gap_nxt;
      cluster_clock_en  <= en_nxt;
      cluster_bias_ctrl <= ~en_nxt;
      dispatch_ready    <= dr_nxt;
      grant_id          <= grant_id_nxt;
      done_pulse        <= done_nxt;
      abort_pulse       <= abort_nxt;
      abort_flag        <= abort_flag_nxt;
    end
  end

endmodule
